// File: rtl/bp_me_axi_addr_arb_pkg.sv
// Shared types for the ME AXI slave address arbiter: FSM states and AXI response codes.
package bp_me_axi_addr_arb_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_busy,
    e_resp
  } bp_me_axi_arb_state_e;

  // AXI BRESP/RRESP encodings; only OKAY is ever produced here.
  localparam logic [1:0] axi_resp_okay_lp   = 2'b00;
  localparam logic [1:0] axi_resp_exokay_lp = 2'b01;
  localparam logic [1:0] axi_resp_slverr_lp = 2'b10;
  localparam logic [1:0] axi_resp_decerr_lp = 2'b11;

endpackage

// File: rtl/bp_me_axi_addr_arb.sv
// Round-robin arbiter that shares one AXI transfer pump between the AW and AR channels,
// keeping exactly one transaction outstanding and issuing the B response for writes.
module bp_me_axi_addr_arb
  import bp_me_axi_addr_arb_pkg::*;
#(
  parameter int axi_addr_width_p = 64,
  parameter int axi_id_width_p   = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [axi_addr_width_p-1:0] s_axi_awaddr_i,
  input  logic [1:0]                  s_axi_awburst_i,
  input  logic [7:0]                  s_axi_awlen_i,
  input  logic [2:0]                  s_axi_awsize_i,
  input  logic [axi_id_width_p-1:0]   s_axi_awid_i,
  input  logic                        s_axi_awvalid_i,
  output logic                        s_axi_awready_o,

  input  logic [axi_addr_width_p-1:0] s_axi_araddr_i,
  input  logic [1:0]                  s_axi_arburst_i,
  input  logic [7:0]                  s_axi_arlen_i,
  input  logic [2:0]                  s_axi_arsize_i,
  input  logic [axi_id_width_p-1:0]   s_axi_arid_i,
  input  logic                        s_axi_arvalid_i,
  output logic                        s_axi_arready_o,

  output logic [axi_id_width_p-1:0]   s_axi_bid_o,
  output logic [1:0]                  s_axi_bresp_o,
  output logic                        s_axi_bvalid_o,
  input  logic                        s_axi_bready_i,

  output logic                        pump_v_o,
  input  logic                        pump_ready_and_i,
  output logic [axi_addr_width_p-1:0] pump_axaddr_o,
  output logic [1:0]                  pump_axburst_o,
  output logic [7:0]                  pump_axlen_o,
  output logic [2:0]                  pump_axsize_o,
  input  logic                        pump_done_i,

  output logic                        is_write_o,
  output logic [axi_id_width_p-1:0]   id_o,
  output logic                        busy_o
);

  bp_me_axi_arb_state_e state_r;
  logic                      last_w_r;
  logic                      is_write_r;
  logic [axi_id_width_p-1:0] id_r;

  logic offering;
  logic grant_w;
  logic accept;

  // Writes win unless a read is also waiting and the previous grant was a write.
  assign offering = (state_r == e_idle) & ~reset_i;
  assign grant_w  = s_axi_awvalid_i & (~s_axi_arvalid_i | ~last_w_r);
  assign accept   = pump_v_o & pump_ready_and_i;

  always_comb begin
    pump_v_o        = 1'b0;
    s_axi_awready_o = 1'b0;
    s_axi_arready_o = 1'b0;
    pump_axaddr_o   = s_axi_araddr_i;
    pump_axburst_o  = s_axi_arburst_i;
    pump_axlen_o    = s_axi_arlen_i;
    pump_axsize_o   = s_axi_arsize_i;
    if (grant_w) begin
      pump_axaddr_o  = s_axi_awaddr_i;
      pump_axburst_o = s_axi_awburst_i;
      pump_axlen_o   = s_axi_awlen_i;
      pump_axsize_o  = s_axi_awsize_i;
    end
    if (offering) begin
      pump_v_o        = s_axi_awvalid_i | s_axi_arvalid_i;
      s_axi_awready_o = grant_w & pump_ready_and_i;
      s_axi_arready_o = ~grant_w & s_axi_arvalid_i & pump_ready_and_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      last_w_r   <= 1'b0;
      is_write_r <= 1'b0;
      id_r       <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (accept) begin
            id_r       <= grant_w ? s_axi_awid_i : s_axi_arid_i;
            is_write_r <= grant_w;
            last_w_r   <= grant_w;
            state_r    <= e_busy;
          end
        end
        e_busy: begin
          if (pump_done_i)
            state_r <= is_write_r ? e_resp : e_idle;
        end
        e_resp: begin
          if (s_axi_bready_i)
            state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  assign s_axi_bvalid_o = (state_r == e_resp);
  assign s_axi_bid_o    = id_r;
  assign s_axi_bresp_o  = axi_resp_okay_lp;

  assign busy_o     = (state_r != e_idle);
  assign is_write_o = is_write_r;
  assign id_o       = id_r;

  // A done pulse outside a burst means the pump and arbiter disagree on ownership.
  done_only_when_busy: assert property (@(posedge clk_i) disable iff (reset_i)
    pump_done_i |-> (state_r == e_busy));

endmodule

// File: tb/tb_bp_me_axi_addr_arb.sv
// Directed self-checking bench for bp_me_axi_addr_arb with hand-computed expectations.
module tb_bp_me_axi_addr_arb;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] s_axi_awaddr_i;
  logic [1:0]  s_axi_awburst_i;
  logic [7:0]  s_axi_awlen_i;
  logic [2:0]  s_axi_awsize_i;
  logic [3:0]  s_axi_awid_i;
  logic        s_axi_awvalid_i;
  logic        s_axi_awready_o;
  logic [63:0] s_axi_araddr_i;
  logic [1:0]  s_axi_arburst_i;
  logic [7:0]  s_axi_arlen_i;
  logic [2:0]  s_axi_arsize_i;
  logic [3:0]  s_axi_arid_i;
  logic        s_axi_arvalid_i;
  logic        s_axi_arready_o;
  logic [3:0]  s_axi_bid_o;
  logic [1:0]  s_axi_bresp_o;
  logic        s_axi_bvalid_o;
  logic        s_axi_bready_i;
  logic        pump_v_o;
  logic        pump_ready_and_i;
  logic [63:0] pump_axaddr_o;
  logic [1:0]  pump_axburst_o;
  logic [7:0]  pump_axlen_o;
  logic [2:0]  pump_axsize_o;
  logic        pump_done_i;
  logic        is_write_o;
  logic [3:0]  id_o;
  logic        busy_o;

  int checkCount = 0;
  int failCount  = 0;

  bp_me_axi_addr_arb #(.axi_addr_width_p(64), .axi_id_width_p(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awburst_i(s_axi_awburst_i),
    .s_axi_awlen_i(s_axi_awlen_i), .s_axi_awsize_i(s_axi_awsize_i),
    .s_axi_awid_i(s_axi_awid_i), .s_axi_awvalid_i(s_axi_awvalid_i),
    .s_axi_awready_o(s_axi_awready_o),
    .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arburst_i(s_axi_arburst_i),
    .s_axi_arlen_i(s_axi_arlen_i), .s_axi_arsize_i(s_axi_arsize_i),
    .s_axi_arid_i(s_axi_arid_i), .s_axi_arvalid_i(s_axi_arvalid_i),
    .s_axi_arready_o(s_axi_arready_o),
    .s_axi_bid_o(s_axi_bid_o), .s_axi_bresp_o(s_axi_bresp_o),
    .s_axi_bvalid_o(s_axi_bvalid_o), .s_axi_bready_i(s_axi_bready_i),
    .pump_v_o(pump_v_o), .pump_ready_and_i(pump_ready_and_i),
    .pump_axaddr_o(pump_axaddr_o), .pump_axburst_o(pump_axburst_o),
    .pump_axlen_o(pump_axlen_o), .pump_axsize_o(pump_axsize_o),
    .pump_done_i(pump_done_i),
    .is_write_o(is_write_o), .id_o(id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives the handshake inputs for this cycle, then lets the combinational paths settle.
  task automatic applyStimulus(input logic aw_v, input logic ar_v, input logic p_rdy,
                               input logic done, input logic b_rdy);
    s_axi_awvalid_i  = aw_v;
    s_axi_arvalid_i  = ar_v;
    pump_ready_and_i = p_rdy;
    pump_done_i      = done;
    s_axi_bready_i   = b_rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    reset_i         = 1'b1;
    s_axi_awaddr_i  = 64'h1000; s_axi_awburst_i = 2'd1; s_axi_awlen_i = 8'd3;
    s_axi_awsize_i  = 3'd3;     s_axi_awid_i    = 4'd5;
    s_axi_araddr_i  = 64'h2040; s_axi_arburst_i = 2'd1; s_axi_arlen_i = 8'd0;
    s_axi_arsize_i  = 3'd2;     s_axi_arid_i    = 4'd2;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_awready", 64'(s_axi_awready_o), 64'd0);
    checkOutput("rst_pump_v", 64'(pump_v_o), 64'd0);
    tick();
    reset_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_bvalid", 64'(s_axi_bvalid_o), 64'd0);
    checkOutput("rst_id", 64'(id_o), 64'd0);
    checkOutput("rst_is_write", 64'(is_write_o), 64'd0);
    checkOutput("rst_arready", 64'(s_axi_arready_o), 64'd0);

    // Write only: awlen=3, id=5, done on the fourth send.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("w_pump_v", 64'(pump_v_o), 64'd1);
    checkOutput("w_awready", 64'(s_axi_awready_o), 64'd1);
    checkOutput("w_arready", 64'(s_axi_arready_o), 64'd0);
    checkOutput("w_addr", pump_axaddr_o, 64'h1000);
    checkOutput("w_len", 64'(pump_axlen_o), 64'd3);
    checkOutput("w_size", 64'(pump_axsize_o), 64'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("w_awready_once", 64'(s_axi_awready_o), 64'd0);
    checkOutput("w_busy", 64'(busy_o), 64'd1);
    checkOutput("w_is_write", 64'(is_write_o), 64'd1);
    checkOutput("w_id", 64'(id_o), 64'd5);
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("w_bvalid_early", 64'(s_axi_bvalid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, i == 3);
      checkOutput("w_bvalid", 64'(s_axi_bvalid_o), 64'd1);
      checkOutput("w_bid", 64'(s_axi_bid_o), 64'd5);
      checkOutput("w_bresp", 64'(s_axi_bresp_o), 64'd0);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("w_bvalid_drop", 64'(s_axi_bvalid_o), 64'd0);
    checkOutput("w_idle", 64'(busy_o), 64'd0);

    // Read only: arlen=0, id=2.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("r_arready", 64'(s_axi_arready_o), 64'd1);
    checkOutput("r_awready", 64'(s_axi_awready_o), 64'd0);
    checkOutput("r_addr", pump_axaddr_o, 64'h2040);
    checkOutput("r_len", 64'(pump_axlen_o), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("r_busy", 64'(busy_o), 64'd1);
    checkOutput("r_is_write", 64'(is_write_o), 64'd0);
    checkOutput("r_id", 64'(id_o), 64'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("r_idle", 64'(busy_o), 64'd0);
    checkOutput("r_no_bvalid", 64'(s_axi_bvalid_o), 64'd0);

    // Both channels valid from reset: grants alternate W,R,W,R...
    tick();
    reset_i = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_i = 1'b0;
    s_axi_awaddr_i = 64'hA000; s_axi_awid_i = 4'd7;
    s_axi_araddr_i = 64'hB000; s_axi_arid_i = 4'd3;
    for (int i = 0; i < 8; i++) begin
      logic expW;
      expW = (i % 2 == 0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("alt_awready", 64'(s_axi_awready_o), 64'(expW));
      checkOutput("alt_arready", 64'(s_axi_arready_o), 64'(!expW));
      checkOutput("alt_addr", pump_axaddr_o, expW ? 64'hA000 : 64'hB000);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("alt_is_write", 64'(is_write_o), 64'(expW));
      checkOutput("alt_id", 64'(id_o), expW ? 64'd7 : 64'd3);
      tick();
      if (expW) begin
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("alt_bvalid", 64'(s_axi_bvalid_o), 64'd1);
        checkOutput("alt_bid", 64'(s_axi_bid_o), 64'd7);
        tick();
      end
    end

    // Read arrives while a write is in flight: held off until after the B handshake.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_awready", 64'(s_axi_awready_o), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_arready_busy", 64'(s_axi_arready_o), 64'd0);
    checkOutput("hold_pump_v_busy", 64'(pump_v_o), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("hold_arready_busy2", 64'(s_axi_arready_o), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_arready_resp", 64'(s_axi_arready_o), 64'd0);
    checkOutput("hold_bvalid", 64'(s_axi_bvalid_o), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("hold_arready_resp2", 64'(s_axi_arready_o), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_arready_grant", 64'(s_axi_arready_o), 64'd1);
    checkOutput("hold_addr", pump_axaddr_o, 64'hB000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();

    // Pump back-pressure: three stalled cycles, accept on the fourth.
    s_axi_awaddr_i = 64'hC0DE0; s_axi_awlen_i = 8'd7; s_axi_awid_i = 4'd9;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_awready", 64'(s_axi_awready_o), 64'd0);
      checkOutput("bp_pump_v", 64'(pump_v_o), 64'd1);
      checkOutput("bp_addr", pump_axaddr_o, 64'hC0DE0);
      checkOutput("bp_len", 64'(pump_axlen_o), 64'd7);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_awready_accept", 64'(s_axi_awready_o), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bp_busy", 64'(busy_o), 64'd1);
    checkOutput("bp_id", 64'(id_o), 64'd9);
    tick();

    // Reset while the B response is pending drops it for good.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rr_bvalid_before", 64'(s_axi_bvalid_o), 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("rr_bvalid", 64'(s_axi_bvalid_o), 64'd0);
    checkOutput("rr_busy", 64'(busy_o), 64'd0);
    checkOutput("rr_id", 64'(id_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("rr_no_stale_b", 64'(s_axi_bvalid_o), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
